// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative restoring divider, signed/unsigned, quotient and remainder
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start, sign, a, b   request pulse, 1=signed, dividend, divisor (captured on accepted start)
//   busy, done          division in progress, one-cycle result-valid pulse
//   quotient, remainder results (held until the next completed division)
//   div_by_zero         captured divisor was zero
module seq_divider #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         sign,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [N:0]    prem;    // partial remainder
    logic [N-1:0]  dq;      // dividend shifts out of the top, quotient bits shift in at the bottom
    logic [N-1:0]  b_abs;
    logic [N-1:0]  a_cap;   // dividend as presented, returned as remainder on divide-by-zero
    logic          neg_a;
    logic          neg_b;
    logic          b_zero;

    logic [N-1:0]  abs_a;
    logic [N-1:0]  abs_b;
    logic [N:0]    shifted;
    logic [N+1:0]  diff;

    // Magnitudes; the most-negative value maps onto itself, which reads correctly as unsigned.
    assign abs_a   = (sign && a[N-1]) ? -a : a;
    assign abs_b   = (sign && b[N-1]) ? -b : b;
    assign shifted = {prem[N-1:0], dq[N-1]};
    // One extra bit so the trial subtraction's sign is unambiguous.
    assign diff    = {1'b0, shifted} - {2'b00, b_abs};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            prem        <= '0;
            dq          <= '0;
            b_abs       <= '0;
            a_cap       <= '0;
            neg_a       <= 1'b0;
            neg_b       <= 1'b0;
            b_zero      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state  <= S_RUN;
                        busy   <= 1'b1;
                        neg_a  <= sign & a[N-1];
                        neg_b  <= sign & b[N-1];
                        dq     <= abs_a;
                        b_abs  <= abs_b;
                        a_cap  <= a;
                        b_zero <= (b == '0);
                        cnt    <= CW'(N - 1);
                        prem   <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (!diff[N+1]) begin
                        prem <= diff[N:0];
                        dq   <= {dq[N-2:0], 1'b1};
                    end else begin
                        prem <= shifted;
                        dq   <= {dq[N-2:0], 1'b0};
                    end
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) state <= S_FIX;
                end
                S_FIX: begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    if (b_zero) begin
                        quotient    <= '1;
                        remainder   <= a_cap;
                        div_by_zero <= 1'b1;
                    end else begin
                        // neg_a/neg_b are only ever set in signed mode.
                        quotient    <= (neg_a ^ neg_b) ? -dq : dq;
                        remainder   <= neg_a ? -prem[N-1:0] : prem[N-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider
module tb_seq_divider;

    localparam int N = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    logic        rs;
    logic [31:0] rx, ry;
    logic [31:0] eq1, er1, eq2, er2;
    logic        ez1, ez2;
    int          lat;

    seq_divider #(.N(N)) dut (
        .clk(clk), .reset(reset), .start(start), .sign(sign), .a(a), .b(b),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, truncating division, remainder follows dividend.
    function automatic void model(input logic s, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
        longint lx, ly;
        if (y == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = x;
            z = 1'b1;
        end else begin
            if (s) begin
                lx = longint'($signed(x));
                ly = longint'($signed(y));
            end else begin
                lx = longint'({32'd0, x});
                ly = longint'({32'd0, y});
            end
            q = 32'(lx / ly);
            r = 32'(lx % ly);
            z = 1'b0;
        end
    endfunction

    task automatic run_op(input logic s, input logic [31:0] x, input logic [31:0] y,
                          input bit disturb, input string tag);
        logic [31:0] eq, er, q0, r0;
        logic        ez, z0;
        int          n;
        bit          busy_ok, hold_ok;
        model(s, x, y, eq, er, ez);
        @(negedge clk);
        sign = s; a = x; b = y; start = 1'b1;
        q0 = quotient; r0 = remainder; z0 = div_by_zero;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; sign = 1'($urandom_range(0, 1));
        check({tag, ".busy_rise"}, 32'(busy), 32'd1);
        n = 0; busy_ok = 1'b1; hold_ok = 1'b1;
        while (done !== 1'b1 && n < N + 8) begin
            if (disturb && n == 5) start = 1'b1;
            if (disturb && n == 6) start = 1'b0;
            @(posedge clk); #1;
            n++;
            if (done !== 1'b1) begin
                if (busy !== 1'b1) busy_ok = 1'b0;
                if (quotient !== q0 || remainder !== r0 || div_by_zero !== z0) hold_ok = 1'b0;
            end
        end
        check({tag, ".latency"}, 32'(n), 32'(N + 1));
        check({tag, ".busy_held"}, 32'(busy_ok), 32'd1);
        check({tag, ".results_held"}, 32'(hold_ok), 32'd1);
        check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
        check({tag, ".q"}, quotient, eq);
        check({tag, ".r"}, remainder, er);
        check({tag, ".dbz"}, 32'(div_by_zero), 32'(ez));
        @(posedge clk); #1;
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; sign = 1'b0; a = '0; b = '0;
        #2;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.q", quotient, 32'd0);
        check("rst.r", remainder, 32'd0);
        check("rst.dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        run_op(1'b0, 32'd100, 32'd7, 1'b0, "u100_7");
        run_op(1'b1, 32'd7, 32'd2, 1'b0, "s7_2");
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, "sm7_2");
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, "s7_m2");
        run_op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0, "sm7_m2");
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "s_ovf");
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, "u_max_1");
        run_op(1'b0, 32'd5, 32'd9, 1'b0, "u5_9");
        run_op(1'b1, 32'h1234_5678, 32'd0, 1'b0, "dbz");
        run_op(1'b1, 32'd9, 32'd3, 1'b0, "after_dbz");
        run_op(1'b1, 32'hFFFF_FC18, 32'd37, 1'b1, "disturb");

        // Back-to-back with start held through the done cycle.
        model(1'b0, 32'd1000, 32'd10, eq1, er1, ez1);
        model(1'b1, 32'hFFFF_FFCE, 32'd3, eq2, er2, ez2);
        @(negedge clk);
        sign = 1'b0; a = 32'd1000; b = 32'd10; start = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (done !== 1'b1 && lat < N + 8) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b.lat1", 32'(lat), 32'(N + 1));
        check("b2b.q1", quotient, eq1);
        check("b2b.r1", remainder, er1);
        sign = 1'b1; a = 32'hFFFF_FFCE; b = 32'd3;
        @(posedge clk); #1;
        check("b2b.busy_again", 32'(busy), 32'd1);
        check("b2b.done_low", 32'(done), 32'd0);
        check("b2b.q1_held", quotient, eq1);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < N + 8) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b.done_spacing", 32'(lat), 32'(N + 2));
        check("b2b.q2", quotient, eq2);
        check("b2b.r2", remainder, er2);
        check("b2b.dbz2", 32'(div_by_zero), 32'(ez2));

        for (int i = 0; i < 20; i++) begin
            rs = 1'($urandom_range(0, 1));
            rx = $urandom;
            case ($urandom_range(0, 3))
                0:       ry = 32'd0;
                1:       ry = $urandom_range(1, 15);
                2:       ry = -($urandom_range(1, 15));
                default: ry = $urandom;
            endcase
            run_op(rs, rx, ry, 1'b0, "rand");
        end

        // Asynchronous reset in the middle of a division.
        run_op(1'b0, 32'hDEAD_BEEF, 32'd0, 1'b0, "pre_rst");
        @(negedge clk);
        sign = 1'b0; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("arst.busy", 32'(busy), 32'd0);
        check("arst.done", 32'(done), 32'd0);
        check("arst.q", quotient, 32'd0);
        check("arst.r", remainder, 32'd0);
        check("arst.dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op(1'b0, 32'd100, 32'd7, 1'b0, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
